csr_trap_unit: RTL

CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

---
 rtl/csr_trap_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with interrupt entry / mret handling for the M stage.
// A trap or mret redirects fetch in the same cycle. One FLUSH cycle follows
// before interrupts are evaluated again.
module csr_trap_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCM,
  input  logic        returnM,
  input  logic        csr_weM,
  input  logic [11:0] csr_addrM,
  input  logic [31:0] csr_wdataM,
  input  logic        irq_ext,
  input  logic        irq_timer,
  output logic [31:0] csr_rdata,
  output logic        Int_flush,
  output logic        squashM,
  output logic        pc_redirect,
  output logic [31:0] pc_target
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  logic [0:0]  state_reg;
  logic        mstatus_mie_reg;
  logic        mstatus_mpie_reg;
  logic        mie_ext_reg;
  logic        mie_tmr_reg;
  logic        mip_ext_reg;
  logic        mip_tmr_reg;
  logic [29:0] mtvec_reg;
  logic [29:0] mepc_reg;
  logic [31:0] mcause_reg;

  logic        run_active;
  logic        valid_m;
  logic        ext_hit;
  logic        tmr_hit;
  logic        take_irq;
  logic        do_mret;
  logic        csr_wr;
  logic [31:0] rdata_raw;

  // Unused low bits are word-alignment bits the CSRs never store.
  logic unused_bits;
  assign unused_bits = ^{PCM[1:0], csr_wdataM};

  // Trap / mret decisions; reset suppresses both so every output stays 0.
  always_comb begin
    run_active = (state_reg == RUN) && !rst;
    valid_m    = (PCM != 32'd0);
    ext_hit    = mie_ext_reg && mip_ext_reg;
    tmr_hit    = mie_tmr_reg && mip_tmr_reg;
    take_irq   = run_active && mstatus_mie_reg && (ext_hit || tmr_hit) && valid_m && !returnM;
    do_mret    = run_active && returnM && valid_m;
    csr_wr     = csr_weM && !take_irq;
  end

  // Pipeline control outputs.
  always_comb begin
    Int_flush   = take_irq || do_mret || ((state_reg == FLUSH) && !rst);
    squashM     = take_irq;
    pc_redirect = take_irq || do_mret;
    pc_target   = 32'd0;
    if (take_irq) begin
      pc_target = {mtvec_reg, 2'b00};
    end else if (do_mret) begin
      pc_target = {mepc_reg, 2'b00};
    end
  end

  // Combinational CSR read; reads see the pre-write value.
  always_comb begin
    rdata_raw = 32'd0;
    case (csr_addrM)
      ADDR_MSTATUS: rdata_raw = {24'd0, mstatus_mpie_reg, 3'd0, mstatus_mie_reg, 3'd0};
      ADDR_MIE:     rdata_raw = {20'd0, mie_ext_reg, 3'd0, mie_tmr_reg, 7'd0};
      ADDR_MTVEC:   rdata_raw = {mtvec_reg, 2'b00};
      ADDR_MEPC:    rdata_raw = {mepc_reg, 2'b00};
      ADDR_MCAUSE:  rdata_raw = mcause_reg;
      ADDR_MIP:     rdata_raw = {20'd0, mip_ext_reg, 3'd0, mip_tmr_reg, 7'd0};
      default:      rdata_raw = 32'd0;
    endcase
    csr_rdata = rst ? 32'd0 : rdata_raw;
  end

  // CSR state and FSM; trap/mret updates are placed after the software
  // write so they win on any bits both touch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= RUN;
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_ext_reg      <= 1'b0;
      mie_tmr_reg      <= 1'b0;
      mip_ext_reg      <= 1'b0;
      mip_tmr_reg      <= 1'b0;
      mtvec_reg        <= 30'd0;
      mepc_reg         <= 30'd0;
      mcause_reg       <= 32'd0;
    end else begin
      mip_ext_reg <= irq_ext;
      mip_tmr_reg <= irq_timer;

      if (csr_wr) begin
        case (csr_addrM)
          ADDR_MSTATUS: begin
            mstatus_mie_reg  <= csr_wdataM[3];
            mstatus_mpie_reg <= csr_wdataM[7];
          end
          ADDR_MIE: begin
            mie_ext_reg <= csr_wdataM[11];
            mie_tmr_reg <= csr_wdataM[7];
          end
          ADDR_MTVEC:  mtvec_reg  <= csr_wdataM[31:2];
          ADDR_MEPC:   mepc_reg   <= csr_wdataM[31:2];
          ADDR_MCAUSE: mcause_reg <= csr_wdataM;
          default: ;
        endcase
      end

      if (take_irq) begin
        mepc_reg         <= PCM[31:2];
        mcause_reg       <= ext_hit ? 32'h8000_000B : 32'h8000_0007;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
        state_reg        <= FLUSH;
      end else if (do_mret) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
        state_reg        <= FLUSH;
      end else if (state_reg == FLUSH) begin
        state_reg <= RUN;
      end
    end
  end

endmodule
